// File: rtl/frame_bram_arbiter_if.sv
// Purpose: bundles the requester, BRAM-port and status signals of frame_bram_arbiter.
// Latency: none (wires only). master = requesters + BRAM side, slave = the arbiter.
// Backpressure: each requester holds req/addr/data until it samples its gnt high.
interface frame_bram_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  logic              freeze;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              wr_gnt;
  logic              tx_req;
  logic [ADDR_W-1:0] tx_addr;
  logic              tx_gnt;
  logic              tx_rvalid;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] bram_dout;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;
  logic              frozen;
  logic              oor_err;

  modport master (
    output freeze, disp_req, disp_addr, wr_req, wr_addr, wr_data, wr_last,
           tx_req, tx_addr, bram_dout,
    input  disp_gnt, disp_rvalid, wr_gnt, tx_gnt, tx_rvalid, rdata,
           bram_addr, bram_din, bram_we, frozen, oor_err
  );

  modport slave (
    input  freeze, disp_req, disp_addr, wr_req, wr_addr, wr_data, wr_last,
           tx_req, tx_addr, bram_dout,
    output disp_gnt, disp_rvalid, wr_gnt, tx_gnt, tx_rvalid, rdata,
           bram_addr, bram_din, bram_we, frozen, oor_err
  );
endinterface

// File: rtl/frame_bram_arbiter.sv
// Purpose: arbitrates the single-port frame BRAM among display read, capture write, tx read;
//          runs the LIVE/FREEZING/FROZEN mode FSM. Ports: clk, rst (async, active-high), bus (slave).
// Latency: grant and BRAM port 0 cycles; rvalid RD_LATENCY cycles after grant.
// Backpressure: requesters wait on gnt; display > write > tx, tx promoted over write when starved.
module frame_bram_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 8,
  parameter int FRAME_WORDS = 256000,
  parameter int RD_LATENCY  = 1,
  parameter int STARVE_MAX  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  frame_bram_arbiter_if.slave   bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  // One extra bit so FRAME_WORDS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]  ADDR_LIM = (ADDR_W + 1)'(FRAME_WORDS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {LIVE, FREEZING, FROZEN} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                  oor_err_q, oor_err_d;
  logic [RD_LATENCY-1:0] disp_tag_q, tx_tag_q;

  logic              gnt_disp, gnt_wr, gnt_tx, gnt_any;
  logic              promote, addr_ok;
  logic [ADDR_W-1:0] gnt_addr;

  // Grant selection: display always first; tx jumps ahead of write once starved.
  // Writes are ineligible while the frame is held.
  always_comb begin
    gnt_disp = 1'b0;
    gnt_wr   = 1'b0;
    gnt_tx   = 1'b0;
    promote  = (starve_cnt_q == CNT_MAX);
    if (bus.disp_req)                         gnt_disp = 1'b1;
    else if (promote && bus.tx_req)           gnt_tx   = 1'b1;
    else if (bus.wr_req && state_q != FROZEN) gnt_wr   = 1'b1;
    else if (bus.tx_req)                      gnt_tx   = 1'b1;
  end

  always_comb begin
    gnt_addr = '0;
    if (gnt_disp)    gnt_addr = bus.disp_addr;
    else if (gnt_wr) gnt_addr = bus.wr_addr;
    else if (gnt_tx) gnt_addr = bus.tx_addr;
  end

  assign gnt_any = gnt_disp | gnt_wr | gnt_tx;
  assign addr_ok = ({1'b0, gnt_addr} < ADDR_LIM);

  assign bus.disp_gnt  = gnt_disp;
  assign bus.wr_gnt    = gnt_wr;
  assign bus.tx_gnt    = gnt_tx;
  assign bus.bram_addr = gnt_addr;
  assign bus.bram_din  = gnt_wr ? bus.wr_data : '0;
  // Out-of-range accesses still get their grant but never touch the BRAM.
  assign bus.bram_we   = gnt_wr && addr_ok;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LIVE:     if (bus.freeze) state_d = FREEZING;
      // Dropping freeze wins over a simultaneous final-pixel write.
      FREEZING: if (!bus.freeze)                  state_d = LIVE;
                else if (gnt_wr && bus.wr_last)   state_d = FROZEN;
      FROZEN:   if (!bus.freeze) state_d = LIVE;
      default:  state_d = LIVE;
    endcase

    starve_cnt_d = '0;
    if (bus.tx_req && !gnt_tx)
      starve_cnt_d = promote ? starve_cnt_q : starve_cnt_q + 1'b1;

    oor_err_d = oor_err_q | (gnt_any && !addr_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LIVE;
      starve_cnt_q <= '0;
      oor_err_q    <= 1'b0;
      disp_tag_q   <= '0;
      tx_tag_q     <= '0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      oor_err_q     <= oor_err_d;
      // Tags follow the BRAM read pipeline; suppressed reads carry no tag.
      disp_tag_q[0] <= gnt_disp && addr_ok;
      tx_tag_q[0]   <= gnt_tx && addr_ok;
      for (int i = 1; i < RD_LATENCY; i++) begin
        disp_tag_q[i] <= disp_tag_q[i-1];
        tx_tag_q[i]   <= tx_tag_q[i-1];
      end
    end
  end

  assign bus.disp_rvalid = disp_tag_q[RD_LATENCY-1];
  assign bus.tx_rvalid   = tx_tag_q[RD_LATENCY-1];
  assign bus.rdata       = bus.bram_dout;
  assign bus.frozen      = (state_q == FROZEN);
  assign bus.oor_err     = oor_err_q;
endmodule
